// File: rtl/reg_file_mp.sv
// Multi-port register file: NUM_RD combinational reads, two synchronous writes, port 1 wins on collision.
// Latency: reads 0 cycles (optional same-cycle bypass), writes land at the next edge; clear sweep takes DEPTH cycles.
// Backpressure: none; writes issued while busy are discarded and flagged one cycle later on wr_drop.
module reg_file_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       we0,
    input  logic [ADDR_W-1:0]          waddr0,
    input  logic [DATA_W-1:0]          wdata0,
    input  logic                       we1,
    input  logic [ADDR_W-1:0]          waddr1,
    input  logic [DATA_W-1:0]          wdata1,
    input  logic [NUM_RD*ADDR_W-1:0]   raddr,
    output logic [NUM_RD*DATA_W-1:0]   rdata,
    input  logic                       clr_req,
    output logic                       busy,
    output logic                       wr_drop
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_ptr;
    logic                r_busy;
    logic                r_wr_drop;
    logic [DATA_W-1:0]   r_mem [DEPTH];

    logic                w_we0_eff;
    logic                w_we1_eff;

    // A write to the hardwired-zero entry is a no-op and is never reported as dropped.
    assign w_we0_eff = we0 && !((ZERO_REG != 0) && (waddr0 == '0));
    assign w_we1_eff = we1 && !((ZERO_REG != 0) && (waddr1 == '0));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_ptr     <= '0;
            r_busy    <= 1'b0;
            r_wr_drop <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            r_wr_drop <= r_busy && (w_we0_eff || w_we1_eff);
            case (r_state)
                IDLE: begin
                    if (w_we0_eff) begin
                        r_mem[waddr0] <= wdata0;
                    end
                    if (w_we1_eff) begin
                        r_mem[waddr1] <= wdata1;
                    end
                    if (clr_req) begin
                        r_state <= SWEEP;
                        r_ptr   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                SWEEP: begin
                    r_mem[r_ptr] <= '0;
                    if (r_ptr == ADDR_W'(DEPTH - 1)) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_ptr   <= '0;
                    end else begin
                        r_ptr <= r_ptr + ADDR_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] w_ra;
        logic [DATA_W-1:0] w_rd;

        assign w_ra = raddr[k*ADDR_W +: ADDR_W];

        // Port 1 is checked last so it overrides port 0 when both hit the same entry.
        always_comb begin
            w_rd = r_mem[w_ra];
            if ((BYPASS != 0) && !r_busy) begin
                if (we0 && (waddr0 == w_ra)) begin
                    w_rd = wdata0;
                end
                if (we1 && (waddr1 == w_ra)) begin
                    w_rd = wdata1;
                end
            end
            if ((ZERO_REG != 0) && (w_ra == '0)) begin
                w_rd = '0;
            end
        end

        assign rdata[k*DATA_W +: DATA_W] = w_rd;
    end

    assign busy    = r_busy;
    assign wr_drop = r_wr_drop;

endmodule
